// File: rtl/param_reg_file_pkg.sv
// Shared processor datapath types and the writeback opcode decode.
// Latency: n/a (types/functions only). Backpressure: none.
package proc_pkg;

  localparam int OP_W      = 3;
  localparam int WR_OP_MAX = 4;
  localparam int DATA_W    = 6;
  localparam int ADDR_W    = 3;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Opcodes 1..op_max commit a register write; 0 and anything above are non-writing.
  function automatic logic is_write_op(input int unsigned op,
                                       input int unsigned op_max = WR_OP_MAX);
    return (op != 0) && (op <= op_max);
  endfunction

endpackage

// File: rtl/param_reg_file_if.sv
// Decode/writeback side bundle of the register file: reads, reservations, writes.
// Latency: reads combinational, writes/reserves on next edge. Backpressure: none.
interface param_reg_file_if
  import proc_pkg::*;
#(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int ADDR_W = proc_pkg::ADDR_W,
  parameter int NUM_RD = 3,
  parameter int OP_W   = proc_pkg::OP_W
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [OP_W-1:0]          opcode;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     rsv_valid;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [DEPTH-1:0]         busy;
  logic [15:0]              wr_cnt;

  modport master (
    output opcode, wr_addr, wr_data, rd_addr, rsv_valid, rsv_addr,
    input  rd_data, rd_busy, busy, wr_cnt
  );

  modport slave (
    input  opcode, wr_addr, wr_data, rd_addr, rsv_valid, rsv_addr,
    output rd_data, rd_busy, busy, wr_cnt
  );

endinterface

// File: rtl/param_reg_file_rf_read_port.sv
// One read port: register mux with same-cycle write bypass and busy lookup.
// Latency: combinational. Backpressure: none.
module rf_read_port #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] regs,
  input  logic [DEPTH-1:0]             busy,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rd_busy
);

  logic hit;

  // A write landing this cycle both forwards its data and clears the hazard.
  assign hit     = wr_en && (wr_addr == rd_addr);
  assign rd_data = hit ? wr_data : regs[rd_addr];
  assign rd_busy = busy[rd_addr] && !hit;

endmodule

// File: rtl/param_reg_file.sv
// Multi-port register file with write bypass and busy scoreboard; PARAM_REG_FILE_ZERO_REG_EN hardwires reg 0.
// Latency: reads combinational, write/reserve commit on clk edge. Backpressure: none, issue logic stalls on busy.
module param_reg_file #(
  parameter int DATA_W    = 6,
  parameter int ADDR_W    = 3,
  parameter int NUM_RD    = 3,
  parameter int OP_W      = 3,
  parameter int WR_OP_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  param_reg_file_if.slave  bus
);
  import proc_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy_q;
  logic [15:0]                  cnt_q;
  logic                         wr_dec;
  logic                         wr_en;
  logic                         rsv_en;

  assign wr_dec = is_write_op(32'(bus.opcode), WR_OP_MAX);

`ifdef PARAM_REG_FILE_ZERO_REG_EN
  // Register 0 is constant zero: its writes and reservations vanish entirely.
  assign wr_en  = wr_dec && (bus.wr_addr != '0);
  assign rsv_en = bus.rsv_valid && (bus.rsv_addr != '0);
`else
  assign wr_en  = wr_dec;
  assign rsv_en = bus.rsv_valid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs   <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) begin
        regs[bus.wr_addr]   <= bus.wr_data;
        busy_q[bus.wr_addr] <= 1'b0;
        if (cnt_q != 16'hFFFF) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      // Placed after the write so a same-address reservation leaves the register busy.
      if (rsv_en) begin
        busy_q[bus.rsv_addr] <= 1'b1;
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.wr_cnt = cnt_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_port (
      .regs    (regs),
      .busy    (busy_q),
      .wr_en   (wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_addr (bus.rd_addr[i*ADDR_W +: ADDR_W]),
      .rd_data (bus.rd_data[i*DATA_W +: DATA_W]),
      .rd_busy (bus.rd_busy[i])
    );
  end

endmodule
